// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor, LSB first, one result bit per clock.
// diff = a - b - bin (mod 2^WIDTH); bout = 1 when a < b + bin (unsigned).
//
// Handshake: start is a request sampled only while idle (busy=0). On the
// edge that accepts it, a/b/bin are captured and later input changes are
// ignored. done is a one-cycle pulse, and diff/bout are valid from that
// cycle until the next done. A start seen while busy is dropped, not queued.
module serial_sub #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   // Encoding picked so busy is state[0] and done is state[1]: each output
   // is a single flop bit, so neither can glitch on a state change.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b11
   } state_t;

   state_t           state;
   state_t           state_next;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic             br;
   logic [CNT_W-1:0] cnt;

   logic             bit_res;
   logic             br_next;
   logic [WIDTH-1:0] res_next;
   logic [WIDTH-1:0] bit_vec;
   logic             last_bit;

   // One full-subtractor cell plus the result shift-in from the MSB end.
   always_comb begin
      bit_vec          = '0;
      bit_res          = a_sh[0] ^ b_sh[0] ^ br;
      br_next          = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
      bit_vec[WIDTH-1] = bit_res;
      res_next         = (res_sh >> 1) | bit_vec;
      last_bit         = (cnt == CNT_W'(WIDTH - 1));
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: IDLE -> RUN on start, RUN -> DONE after the last bit,
   // DONE -> IDLE unconditionally.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (start)    state_next = ST_RUN;
         ST_RUN:  if (last_bit) state_next = ST_DONE;
         ST_DONE:               state_next = ST_IDLE;
         default:               state_next = ST_IDLE;
      endcase
   end

   assign busy = state[0];
   assign done = state[1];

   // Datapath: capture on accept, shift one bit per RUN cycle, publish the
   // complete result only on the edge that processes the final bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         br     <= 1'b0;
         cnt    <= '0;
         diff   <= '0;
         bout   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  a_sh   <= a;
                  b_sh   <= b;
                  br     <= bin;
                  res_sh <= '0;
                  cnt    <= '0;
               end
            end
            ST_RUN: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               br     <= br_next;
               res_sh <= res_next;
               cnt    <= cnt + CNT_W'(1);
               if (last_bit) begin
                  diff <= res_next;
                  bout <= br_next;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: directed and random checks of serial_sub at WIDTH=8, plus
// an exhaustive sweep of a WIDTH=4 instance against an arithmetic model.
module tb_serial_sub;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;

   logic       start8, bin8, busy8, done8, bout8;
   logic [7:0] a8, b8, diff8;

   logic       start4, bin4, busy4, done4, bout4;
   logic [3:0] a4, b4, diff4;

   serial_sub #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
      .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
   );

   serial_sub #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
      .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
   );

   // ---------------- scoreboard ----------------
   int n_tests = 0;
   int n_fail  = 0;

   // Last published result of each instance, packed as {bout, diff}.
   logic [31:0] last8 = 32'd0;
   logic [31:0] last4 = 32'd0;

   // Reference: plain integer subtraction; the borrow is the sign.
   function automatic logic [31:0] ref_sub(input int w, input int a, input int b, input int bin);
      int d;
      int m;
      d = a - b - bin;
      m = d & ((1 << w) - 1);
      ref_sub = 32'(m) | ((d < 0) ? 32'(1 << w) : 32'd0);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- drivers ----------------
   // Called at a negedge with dut8 idle; returns at a negedge with dut8 idle.
   // Inputs (including start) are scrambled while the op is in flight.
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin);
      logic [31:0] exp;
      exp    = ref_sub(8, int'(a), int'(b), int'(bin));
      start8 = 1'b1;
      a8     = a;
      b8     = b;
      bin8   = bin;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         if (n <= 8) begin
            chk("busy8_run", 32'(busy8), 32'd1);
            chk("done8_early", 32'(done8), 32'd0);
            chk("hold8_run", {23'd0, bout8, diff8}, last8);
         end else if (n == 9) begin
            chk("done8_pulse", 32'(done8), 32'd1);
            chk("busy8_done", 32'(busy8), 32'd1);
            chk("res8", {23'd0, bout8, diff8}, exp);
            last8 = exp;
         end else begin
            chk("done8_after", 32'(done8), 32'd0);
            chk("busy8_idle", 32'(busy8), 32'd0);
            chk("hold8_idle", {23'd0, bout8, diff8}, last8);
         end
         if (n <= 9) begin
            start8 = 1'($urandom_range(0, 1));
            a8     = 8'($urandom);
            b8     = 8'($urandom);
            bin8   = 1'($urandom);
         end else begin
            start8 = 1'b0;
         end
      end
   endtask

   task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bin);
      logic [31:0] exp;
      exp    = ref_sub(4, int'(a), int'(b), int'(bin));
      start4 = 1'b1;
      a4     = a;
      b4     = b;
      bin4   = bin;
      for (int n = 1; n <= 6; n++) begin
         @(negedge clk);
         if (n <= 4) begin
            chk("done4_early", 32'(done4), 32'd0);
         end else if (n == 5) begin
            chk("done4_pulse", 32'(done4), 32'd1);
            chk("res4", {27'd0, bout4, diff4}, exp);
            last4 = exp;
         end else begin
            chk("done4_after", 32'(done4), 32'd0);
            chk("busy4_idle", 32'(busy4), 32'd0);
         end
         start4 = (n <= 5) ? 1'($urandom_range(0, 1)) : 1'b0;
         a4     = 4'($urandom);
         b4     = 4'($urandom);
         bin4   = 1'($urandom);
      end
   endtask

   // ---------------- sequence ----------------
   logic [7:0] qa[31];
   logic [7:0] qb[31];
   logic       qbin[31];

   initial begin
      rst_n  = 1'b1;
      start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
      start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;

      // Asynchronous reset, checked before any clock edge.
      #2 rst_n = 1'b0;
      #1;
      chk("rst_busy", 32'(busy8), 32'd0);
      chk("rst_done", 32'(done8), 32'd0);
      chk("rst_res", {23'd0, bout8, diff8}, 32'd0);
      chk("rst_busy4", 32'(busy4), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Start accepted on the first edge out of reset; directed vectors.
      op8(8'h05, 8'h03, 1'b0);
      op8(8'h03, 8'h05, 1'b0);
      op8(8'h00, 8'h00, 1'b1);
      op8(8'hFF, 8'hFF, 1'b0);
      op8(8'h80, 8'h01, 1'b1);

      // Idle with start low: nothing moves.
      for (int i = 0; i < 3; i++) begin
         a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
         @(negedge clk);
         chk("idle_busy", 32'(busy8), 32'd0);
         chk("idle_hold", {23'd0, bout8, diff8}, last8);
      end

      // Random operands.
      for (int i = 0; i < 30; i++) begin
         op8(8'($urandom), 8'($urandom), 1'($urandom));
      end

      // start held high, operands changing every cycle: ops accepted every
      // 10 edges, each capturing the operands driven just before its edge.
      for (int k = 0; k <= 30; k++) begin
         if (k > 0) begin
            @(negedge clk);
            chk("b2b_done", 32'(done8), 32'((k % 10) == 9));
            chk("b2b_busy", 32'(busy8), 32'((k % 10) != 0));
            if ((k % 10) == 9) begin
               last8 = ref_sub(8, int'(qa[k-9]), int'(qb[k-9]), int'(qbin[k-9]));
            end
            chk("b2b_res", {23'd0, bout8, diff8}, last8);
         end
         qa[k] = 8'($urandom); qb[k] = 8'($urandom); qbin[k] = 1'($urandom);
         a8 = qa[k]; b8 = qb[k]; bin8 = qbin[k];
         start8 = (k < 30) ? 1'b1 : 1'b0;
      end

      // Reset 4 cycles into RUN: aborts with no done and clears the result.
      start8 = 1'b1; a8 = 8'h5A; b8 = 8'h21; bin8 = 1'b0;
      for (int n = 1; n <= 4; n++) begin
         @(negedge clk);
         start8 = 1'b0;
      end
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy8), 32'd0);
      chk("abort_done", 32'(done8), 32'd0);
      chk("abort_res", {23'd0, bout8, diff8}, 32'd0);
      last8 = 32'd0;
      last4 = 32'd0;
      for (int n = 0; n < 2; n++) begin
         @(negedge clk);
         chk("abort_nodone", 32'(done8), 32'd0);
      end
      rst_n = 1'b1;
      op8(8'h5A, 8'h21, 1'b0);
      op8(8'h10, 8'h20, 1'b1);

      // Exhaustive WIDTH=4 sweep.
      for (int ia = 0; ia < 16; ia++) begin
         for (int ib = 0; ib < 16; ib++) begin
            for (int ic = 0; ic < 2; ic++) begin
               op4(4'(ia), 4'(ib), 1'(ic));
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal range 1..32).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 a  input  WIDTH  minuend; captured on an accepted start.
REQ-006 b  input  WIDTH  subtrahend; captured on an accepted start.
REQ-007 bin  input  1  borrow-in; captured on an accepted start.
REQ-008 busy  output  1  high while an operation is in progress (RUN or DONE).
REQ-009 done  output  1  one-cycle pulse marking a valid new result.
REQ-010 diff  output  WIDTH  registered result, a - b - bin mod 2^WIDTH.
REQ-011 bout  output  1  registered borrow-out; 1 when a < b + bin as unsigned values.

Function
REQ-012 FSM states: IDLE, RUN, DONE, using a bit counter of ceil(log2(WIDTH+1)) bits.
REQ-013 IDLE with start=1 at a rising edge: load a, b and bin into internal shift/borrow registers, clear counter, go to RUN.
REQ-014 IDLE with start=0: remain in IDLE, with no change to diff and bout.
REQ-015 RUN, one bit per edge, LSB first: bit = ai ^ bi ^ br; next br = (~ai & bi) | (~(ai ^ bi) & br).
REQ-016 RUN: shift each result bit into an internal result register from the MSB end, shift the operands right by one, and increment the counter.
REQ-017 RUN: after the WIDTH-th bit is processed, go to DONE and transfer the internal result to diff and the final borrow to bout on that same edge.
REQ-018 DONE: done=1 for exactly one cycle, then unconditional transition to IDLE.
REQ-019 Latency: with start accepted at edge t, done is high during the cycle following edge t+WIDTH, and diff/bout are valid from that cycle on.
REQ-020 busy=1 in RUN and DONE, 0 in IDLE; busy and done are decoded from state and are glitch-free registered-state outputs.
REQ-021 start while in RUN or DONE is ignored, with no queuing and no restart.
REQ-022 Changes on a, b or bin after acceptance have no effect on the operation in progress.
REQ-023 diff/bout hold their value from the last completion until the next completion; they never show partial results.
REQ-024 Back-to-back: start high in the first IDLE cycle after DONE is accepted, so throughput is one result per WIDTH+2 cycles.
REQ-025 WIDTH=1: a single RUN cycle, and the result equals a 1-bit full subtract.

Reset
REQ-026 rst_n=0 forces immediately (without waiting for clk): state=IDLE, busy=0, done=0, diff=0, bout=0, counter, shift and borrow registers = 0.
REQ-027 Reset asserted mid-RUN or in DONE aborts the operation with no done pulse and no result update; after release the block is in IDLE awaiting start.
REQ-028 First start is accepted on the first rising edge with rst_n=1.

Verification (WIDTH=8)
REQ-029 a=0x05, b=0x03, bin=0, start pulse -> 8 RUN cycles, then done=1 for 1 cycle, diff=0x02, bout=0.
REQ-030 a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1; a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
REQ-031 a=0xFF, b=0xFF, bin=0 -> diff=0x00, bout=0; a=0x80, b=0x01, bin=1 -> diff=0x7E, bout=0.
REQ-032 start held high continuously with operands changed each cycle mid-RUN -> the first result reflects the captured operands, the second op starts in the IDLE cycle after DONE, and done pulses are spaced 10 cycles apart.
REQ-033 rst_n pulsed low 4 cycles into RUN -> busy drops asynchronously, no done pulse, diff/bout=0; the next start yields a correct result.
REQ-034 Exhaustive check with WIDTH=4: all a, b and bin combinations compared against a reference model a - b - bin, checking diff, bout and exact done timing.
